// File: rtl/data_mem_unit.sv
// data_mem_unit: RV32I data-memory stage sitting after the execute ALU.
// It takes the ALU result as a byte address and performs byte, halfword and word loads and
// stores on a synchronous single-port RAM, behind a valid/ready handshake. req_ready low
// stalls the core.
//
// Ports:
//   clk, reset          rising-edge clock; synchronous, active-high reset
//   req_valid/req_ready request handshake (req_ready is high only in IDLE)
//   mem_read/mem_write  load / store request
//   funct3              000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr, wdata         byte address; store data, right-aligned
//   resp_valid          one-cycle response strobe
//   resp_rdata          extended load data (0 for stores and errors)
//   resp_err            access failed, with no memory side effect
//   resp_err_code       00 none, 01 misaligned, 10 out of range, 11 illegal op
module data_mem_unit #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  resp_err_code
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {StIdle, StRd, StRsp} state_e;

    state_e      state_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [31:0] rd_word_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;
    logic [1:0]  resp_err_code_q;

    logic [31:0] ram [DEPTH_WORDS];

    logic          accept;
    logic [31:0]   offset;
    logic [AW-1:0] idx;
    logic          err_illegal, err_misaligned, err_range, any_err;
    logic [1:0]    err_code;
    logic          do_store, do_load;
    logic [3:0]    byte_en;
    logic [31:0]   wdata_lanes;
    logic [31:0]   load_ext;
    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;

    // Requests with neither read nor write are not accepted at all.
    assign req_ready = (state_q == StIdle);
    assign accept    = req_ready && req_valid && (mem_read || mem_write) && !reset;

    // BASE_ADDR is word-aligned, so offset[1:0] is the byte lane within the word.
    assign offset = addr - BASE_ADDR;
    assign idx    = offset[AW+1:2];

    always_comb begin
        err_illegal = 1'b0;
        if (mem_read && mem_write) begin
            err_illegal = 1'b1;
        end
        if (!(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) begin
            err_illegal = 1'b1;
        end
        if (funct3[2] && mem_write) begin
            err_illegal = 1'b1;
        end
        err_misaligned = ((funct3[1:0] == 2'b01) && offset[0]) ||
                         ((funct3 == 3'b010) && (offset[1:0] != 2'b00));
        err_range      = (addr < BASE_ADDR) || ({2'b00, offset[31:2]} >= DEPTH_WORDS);

        any_err  = err_illegal || err_misaligned || err_range;
        err_code = 2'b00;
        if (err_illegal) begin
            err_code = 2'b11;
        end else if (err_misaligned) begin
            err_code = 2'b01;
        end else if (err_range) begin
            err_code = 2'b10;
        end
    end

    assign do_store = accept && !any_err && mem_write;
    assign do_load  = accept && !any_err && mem_read;

    // Replicate store data across lanes; byte enables pick the lanes that are written.
    always_comb begin
        byte_en     = 4'b0000;
        wdata_lanes = wdata;
        case (funct3[1:0])
            2'b00: begin
                byte_en     = 4'b0001 << offset[1:0];
                wdata_lanes = {4{wdata[7:0]}};
            end
            2'b01: begin
                byte_en     = offset[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
            end
            default: begin
                byte_en     = 4'b1111;
                wdata_lanes = wdata;
            end
        endcase
    end

    // RAM: stores commit at the accept edge; a load's word is registered at the same edge.
    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    ram[idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
                end
            end
        end
        if (do_load) begin
            rd_word_q <= ram[idx];
        end
    end

    always_comb begin
        sel_byte = rd_word_q[7:0];
        case (lane_q)
            2'b00:   sel_byte = rd_word_q[7:0];
            2'b01:   sel_byte = rd_word_q[15:8];
            2'b10:   sel_byte = rd_word_q[23:16];
            default: sel_byte = rd_word_q[31:24];
        endcase
        sel_half = lane_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];

        case (funct3_q)
            3'b000:  load_ext = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_ext = {24'h0, sel_byte};
            3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_ext = {16'h0, sel_half};
            default: load_ext = rd_word_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            funct3_q        <= 3'b000;
            lane_q          <= 2'b00;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= 32'h0;
            resp_err_q      <= 1'b0;
            resp_err_code_q <= 2'b00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    resp_valid_q <= 1'b0;
                    if (accept) begin
                        if (do_load) begin
                            funct3_q <= funct3;
                            lane_q   <= offset[1:0];
                            state_q  <= StRd;
                        end else begin
                            // Store or error: respond directly.
                            resp_valid_q    <= 1'b1;
                            resp_rdata_q    <= 32'h0;
                            resp_err_q      <= any_err;
                            resp_err_code_q <= err_code;
                            state_q         <= StRsp;
                        end
                    end
                end
                StRd: begin
                    resp_valid_q    <= 1'b1;
                    resp_rdata_q    <= load_ext;
                    resp_err_q      <= 1'b0;
                    resp_err_code_q <= 2'b00;
                    state_q         <= StRsp;
                end
                StRsp: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= StIdle;
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= StIdle;
                end
            endcase
        end
    end

    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_err      = resp_err_q;
    assign resp_err_code = resp_err_code_q;

endmodule
